br_sched_rr_burst: RTL and testbench
====================================

// Module: br_sched_rr_burst
// PURPOSE
//  Round-robin burst scheduler sharing one downstream resource among NumRequesters.
//  Holds a registered binary grant index for a whole burst.
//  Decodes it to a onehot grant vector through a br_enc_bin2onehot instance.
//  Sits between per-requester valid/last sources and a single valid/ready consumer port.
// PARAMETERS
//  NumRequesters  4      number of requesters; must be >= 2
//  MaxBurstLen    8      max accepted beats per grant; must be >= 1
//  IdxWidth       br_math::clamped_clog2(NumRequesters)  width of binary grant index
//  CountWidth     $clog2(MaxBurstLen+1)                  width of beat counter
// PORTS
//  clk        in   1              clock
//  rst_n      in   1              asynchronous reset, active-low
//  req        in   NumRequesters  per-requester valid; must hold while granted and not accepted
//  req_last   in   NumRequesters  per-requester end-of-burst flag, qualified by req
//  req_ready  out  NumRequesters  out_grant & {N{out_ready}}
//  out_valid  out  1              req[grant_idx] while state==GRANT, else 0
//  out_ready  in   1              consumer accepts beat when out_valid & out_ready
//  out_idx    out  IdxWidth       registered binary grant index (0 when not GRANT)
//  out_grant  out  NumRequesters  onehot of out_idx; all-zero when not GRANT
// BEHAVIOUR
//  Reset: state=IDLE, grant_idx=0, ptr=0, count=0; out_valid=0, out_grant=0, req_ready=0, out_idx=0.
//  Async reset mid-burst: all outputs drop immediately; the burst is abandoned with no replay.
//  Pick function: first set bit of req, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//  IDLE: if |req, grant_idx<=pick, count<=0, state<=GRANT. First beat can be presented the next cycle (1-cycle latency).
//  GRANT: beat = out_valid & out_ready; count increments on each beat.
//  Release condition, any of:
//    (a) beat & req_last[grant_idx];
//    (b) beat & count+1==MaxBurstLen;
//    (c) !req[grant_idx], i.e. requester withdrew (no beat that cycle).
//  On release: ptr <= (grant_idx==N-1) ? 0 : grant_idx+1. Wrap is explicit; no power-of-two assumption.
//  On release, re-arbitrate in the same cycle using the new ptr, with req[grant_idx] masked for cases (a) and (b).
//    If a winner exists: stay in GRANT, load new grant_idx, count<=0. No bubble.
//    Else: go to IDLE.
//  Releasing requester still requesting with no other request: re-granted after one IDLE cycle (fairness bubble).
//  MaxBurstLen==1: every beat releases.
//  Simultaneous last and count limit: single release, identical effect.
//  req changes on non-granted lines have no effect until the next arbitration.
//  Integration assertions:
//    req[grant_idx] & !out_ready in GRANT |=> req[grant_idx] (no withdraw under backpressure).
//    Parameter ranges are checked statically.
//  Implementation assertions:
//    $onehot0(out_grant); out_valid |-> out_grant[out_idx]; count <= MaxBurstLen.
// STRUCTURE
//  No new shared-package content: widths come from br_math.
//  The 2-state enum (IDLE, GRANT) and the pick function are local to the module.
//  One sub-module: br_enc_bin2onehot.
//    Parameters: NumValues=NumRequesters, BinWidth=IdxWidth, EnableAssertFinalNotValid=0.
//    Connections: in=grant_idx, in_valid=(state==GRANT), out=out_grant.
//  Flops: state, grant_idx, ptr, count. All other outputs are combinational from these plus req/out_ready.
// TESTING
//  Reset: hold rst_n=0 with req=4'b1111 -> out_valid=0, out_grant=0; release -> cycle 1 out_grant=4'b0001.
//  Round-robin: req=4'b1111, out_ready=1, req_last=4'b1111 -> grants 0,1,2,3,0 on consecutive cycles, no bubbles.
//  Burst limit: MaxBurstLen=8, req=4'b0011, req_last=0, out_ready=1 -> 8 beats to idx0, then 8 beats to idx1.
//  Backpressure: grant idx2, out_ready=0 for 5 cycles -> out_valid=1 held, count=0; then 3 beats with last on third -> ptr=3.
//  Withdraw/wrap: N=3, grant idx2, req drops to 3'b001 -> release, next grant idx0, ptr=0.
//  Async reset mid-burst after 3 beats: outputs zero in the same cycle; post-reset, idx0 granted first again.

Source files
------------

// File: rtl/br_math_pkg.sv
// Shared width helpers for the br_* library.
package br_math;

  // Width needed to index 'value' items, never less than one bit.
  function automatic int clamped_clog2(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/br_enc_bin2onehot.sv
// Binary-to-onehot decoder; the output is all-zero when in_valid is low.
module br_enc_bin2onehot
  import br_math::*;
#(
  parameter int NumValues = 2,
  parameter int BinWidth = clamped_clog2(NumValues),
  parameter bit EnableAssertFinalNotValid = 1'b1
) (
  input  logic                 in_valid,
  input  logic [BinWidth-1:0]  in,
  output logic [NumValues-1:0] out
);

  always_comb begin
    out = '0;
    for (int i = 0; i < NumValues; i++) begin
      if (in_valid && (in == BinWidth'(i))) out[i] = 1'b1;
    end
  end

  // Catches a decoder still holding a live value when simulation ends.
  if (EnableAssertFinalNotValid) begin : g_final_check
    final begin
      assert (!in_valid);
    end
  end

endmodule

// File: rtl/br_sched_rr_burst.sv
// Round-robin burst scheduler: one requester owns the downstream port for a whole burst.
module br_sched_rr_burst
  import br_math::*;
#(
  parameter int NumRequesters = 4,
  parameter int MaxBurstLen = 8,
  parameter int IdxWidth = clamped_clog2(NumRequesters),
  parameter int CountWidth = $clog2(MaxBurstLen + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NumRequesters-1:0] req,
  input  logic [NumRequesters-1:0] req_last,
  output logic [NumRequesters-1:0] req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IdxWidth-1:0]      out_idx,
  output logic [NumRequesters-1:0] out_grant
);

  if (NumRequesters < 2) begin : g_bad_num_requesters
    $error("NumRequesters must be >= 2");
  end
  if (MaxBurstLen < 1) begin : g_bad_max_burst_len
    $error("MaxBurstLen must be >= 1");
  end

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumRequesters - 1);
  localparam logic [CountWidth-1:0] LastCount = CountWidth'(MaxBurstLen - 1);

  state_e state, state_next;
  logic [IdxWidth-1:0] grant_idx, grant_idx_next, ptr, ptr_next, ptr_release, arb_start;
  logic [CountWidth-1:0] count, count_next;
  logic [NumRequesters-1:0] arb_req;
  logic [IdxWidth:0] winner;
  logic beat, release_full, release_burst, do_arb;

  // Returns {found, index} of the first request at or after 'start', wrapping.
  function automatic logic [IdxWidth:0] pick(input logic [NumRequesters-1:0] r,
                                             input logic [IdxWidth-1:0] start);
    logic found;
    logic [IdxWidth-1:0] idx;
    int pos;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      pos = int'(start) + i;
      if (pos >= NumRequesters) pos -= NumRequesters;
      if (!found && r[pos]) begin
        found = 1'b1;
        idx = pos[IdxWidth-1:0];
      end
    end
    return {found, idx};
  endfunction

  assign out_valid = (state == GRANT) && req[grant_idx];
  assign out_idx = (state == GRANT) ? grant_idx : '0;
  assign req_ready = out_grant & {NumRequesters{out_ready}};
  assign beat = out_valid && out_ready;
  assign release_full = beat && (req_last[grant_idx] || (count == LastCount));
  assign release_burst = release_full || !req[grant_idx];
  assign ptr_release = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;

  br_enc_bin2onehot #(
    .NumValues(NumRequesters),
    .BinWidth(IdxWidth),
    .EnableAssertFinalNotValid(1'b0)
  ) u_grant_dec (
    .in_valid(state == GRANT),
    .in(grant_idx),
    .out(out_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant_idx <= '0;
      ptr <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      grant_idx <= grant_idx_next;
      ptr <= ptr_next;
      count <= count_next;
    end
  end

  // A finishing requester is masked so a completed burst hands over without a bubble.
  always_comb begin
    state_next = state;
    grant_idx_next = grant_idx;
    ptr_next = ptr;
    count_next = count;
    arb_req = req;
    arb_start = ptr;
    do_arb = 1'b0;
    case (state)
      IDLE: do_arb = |req;
      GRANT: begin
        if (beat) count_next = count + 1'b1;
        if (release_burst) begin
          ptr_next = ptr_release;
          arb_start = ptr_release;
          do_arb = 1'b1;
          if (release_full) arb_req[grant_idx] = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
    winner = pick(arb_req, arb_start);
    if (do_arb) begin
      count_next = '0;
      if (winner[IdxWidth]) begin
        state_next = GRANT;
        grant_idx_next = winner[IdxWidth-1:0];
      end else begin
        state_next = IDLE;
      end
    end
  end

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(out_grant));
  a_valid_granted: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> out_grant[out_idx]);
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CountWidth'(MaxBurstLen));
  a_no_withdraw_stalled: assert property (@(posedge clk) disable iff (!rst_n)
    (state == GRANT && req[grant_idx] && !out_ready) |=> req[grant_idx]);

endmodule

// File: tb/tb_br_sched_rr_burst.sv
// Randomized and directed checks of br_sched_rr_burst against a burst-ownership reference model.
module tb_br_sched_rr_burst;

  localparam int N = 4;
  localparam int MaxBurst = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req, req_last, req_ready, out_grant;
  logic out_valid, out_ready;
  logic [1:0] out_idx;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the port (-1 = nobody), where the next search starts, beats served.
  int m_owner;
  int m_ptr;
  int m_beats;
  bit m_hold;

  always #5 clk = ~clk;

  br_sched_rr_burst #(
    .NumRequesters(N),
    .MaxBurstLen(MaxBurst)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_last(req_last),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx(out_idx),
    .out_grant(out_grant)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int rrPick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (start + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic void modelReset();
    m_owner = -1;
    m_ptr = 0;
    m_beats = 0;
    m_hold = 1'b0;
  endfunction

  // Advances ownership by one clock given this cycle's inputs.
  function automatic void modelStep(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy);
    bit served, finished;
    logic [N-1:0] masked;
    int w;
    m_hold = 1'b0;
    if (m_owner < 0) begin
      w = rrPick(r, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_beats = 0;
      end
    end else begin
      served = r[m_owner] && rdy;
      finished = served && (l[m_owner] || (m_beats + 1 == MaxBurst));
      if (served) m_beats++;
      if (finished || !r[m_owner]) begin
        masked = r;
        if (finished) masked[m_owner] = 1'b0;
        m_ptr = (m_owner + 1) % N;
        m_owner = rrPick(masked, m_ptr);
        m_beats = 0;
      end else if (!rdy) begin
        m_hold = 1'b1;
      end
    end
  endfunction

  // Drives one cycle (called just after a falling edge), checks outputs, steps the model.
  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy);
    logic [N-1:0] exp_grant;
    if (m_hold) r[m_owner] = 1'b1;
    req = r;
    req_last = l;
    out_ready = rdy;
    #1;
    exp_grant = '0;
    if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
    checkOutput("out_valid", 32'(out_valid), 32'((m_owner >= 0) && r[m_owner]));
    checkOutput("out_idx", 32'(out_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    checkOutput("out_grant", 32'(out_grant), 32'(exp_grant));
    checkOutput("req_ready", 32'(req_ready), 32'(exp_grant & {N{rdy}}));
    modelStep(r, l, rdy);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 4'b1111;
    req_last = 4'b0000;
    out_ready = 1'b1;
    modelReset();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_hold_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_hold_grant", 32'(out_grant), 32'd0);
    checkOutput("rst_hold_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    checkOutput("rst_first_grant", 32'(out_grant), 32'b0001);

    $display("[TB] round-robin with single-beat bursts");
    repeat (5) applyStimulus(4'b1111, 4'b1111, 1'b1);

    $display("[TB] burst length limit");
    repeat (20) applyStimulus(4'b0011, 4'b0000, 1'b1);

    $display("[TB] backpressure on requester 2");
    repeat (6) applyStimulus(4'b0100, 4'b0000, 1'b0);
    repeat (2) applyStimulus(4'b0100, 4'b0000, 1'b1);
    applyStimulus(4'b0100, 4'b0100, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    checkOutput("bp_ptr_next", 32'(out_idx), 32'd3);

    $display("[TB] withdraw and pointer wrap");
    repeat (2) applyStimulus(4'b1000, 4'b0000, 1'b1);
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkOutput("wrap_grant", 32'(out_grant), 32'b0001);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++)
      applyStimulus(4'($urandom | $urandom), 4'($urandom & $urandom & $urandom),
                    1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 1000; i++)
      applyStimulus(4'($urandom), 4'b0000, 1'($urandom_range(0, 2) != 0));

    $display("[TB] async reset mid-burst");
    repeat (2) applyStimulus(4'b0000, 4'b0000, 1'b1);
    repeat (4) applyStimulus(4'b1111, 4'b0000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_grant", 32'(out_grant), 32'd0);
    checkOutput("midrst_ready", 32'(req_ready), 32'd0);
    checkOutput("midrst_idx", 32'(out_idx), 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    checkOutput("post_rst_idx", 32'(out_idx), 32'd0);
    checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
    repeat (4) applyStimulus(4'b1111, 4'b0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
